ibex_wb_pipe: RTL and testbench

- Single-entry writeback pipeline register directly downstream of the execute block.
- Captures `result_ex_o` plus register-file write metadata when the ID/EX side retires an instruction into WB.
- Holds loads until the LSU response returns, then drives the register-file write port and the forwarding path back to ID.
- Decouples EX completion from RF write so ID can issue the next instruction one cycle earlier.

---
 rtl/ibex_pkg.sv | 12 +
 rtl/ibex_wb_pipe.sv | 148 ++++++++++++++
 tb/tb_ibex_wb_pipe.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types for the writeback pipeline slice.
package ibex_pkg;

    // Instruction class carried from EX into the writeback register.
    typedef enum logic [1:0] {
        WB_INSTR_REG   = 2'd0,  // register-writing ALU / multdiv
        WB_INSTR_LOAD  = 2'd1,
        WB_INSTR_STORE = 2'd2,
        WB_INSTR_OTHER = 2'd3   // retires without an RF write
    } wb_instr_type_e;

endpackage

// File: rtl/ibex_wb_pipe.sv
// Single-entry writeback register between EX and the register file. Holds
// loads/stores until the LSU responds, muxes load data in the response cycle,
// and exposes the held entry as the forwarding source for ID.
module ibex_wb_pipe
    import ibex_pkg::*;
#(
    parameter bit WritebackStage = 1'b1,
    parameter bit ResetAll       = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_wb_i,
    input  logic [1:0]  instr_type_wb_i,
    input  logic [4:0]  rf_waddr_id_i,
    input  logic [31:0] rf_wdata_id_i,
    input  logic        rf_we_id_i,
    input  logic        lsu_resp_valid_i,
    input  logic        lsu_resp_err_i,
    input  logic [31:0] lsu_rdata_i,
    output logic        ready_wb_o,
    output logic [4:0]  rf_waddr_wb_o,
    output logic [31:0] rf_wdata_wb_o,
    output logic        rf_we_wb_o,
    output logic        outstanding_load_wb_o,
    output logic        instr_done_wb_o,
    output logic        resp_unexpected_o
);

    wb_instr_type_e instr_type_in;
    wb_instr_type_e type_q;
    logic           valid_q;
    logic [4:0]     waddr_q;
    logic [31:0]    wdata_q;
    logic           we_q;
    logic           unexp_q;
    logic           unexp_d;

    logic           held_mem;
    logic           completing;
    logic           capture;

    assign instr_type_in = wb_instr_type_e'(instr_type_wb_i);

    // A held load/store is the only state in which an LSU response is legal.
    assign held_mem   = valid_q & ((type_q == WB_INSTR_LOAD) | (type_q == WB_INSTR_STORE));
    // Non-memory entries retire in their first held cycle; memory entries wait for the response.
    assign completing = valid_q & (~held_mem | lsu_resp_valid_i);
    assign capture    = en_wb_i & ready_wb_o;
    assign unexp_d    = unexp_q | (lsu_resp_valid_i & ~held_mem);

    if (WritebackStage) begin : g_wb_stage
        logic valid_d;

        // Occupancy: a capture always (re)fills the entry, otherwise retiring empties it.
        always_comb begin
            valid_d = valid_q;
            if (capture) begin
                valid_d = 1'b1;
            end else if (completing) begin
                valid_d = 1'b0;
            end
        end

        // Control state with asynchronous reset; reset mid-load simply drops the entry.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
            end
        end

        if (ResetAll) begin : g_data_rst
            // Entry payload, cleared on reset in this configuration.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    type_q  <= WB_INSTR_REG;
                    waddr_q <= 5'd0;
                    wdata_q <= 32'd0;
                    we_q    <= 1'b0;
                end else if (capture) begin
                    type_q  <= instr_type_in;
                    waddr_q <= rf_waddr_id_i;
                    wdata_q <= rf_wdata_id_i;
                    we_q    <= rf_we_id_i;
                end
            end
        end else begin : g_data_norst
            // Entry payload; valid_q alone qualifies it, so no reset is needed.
            always_ff @(posedge clk_i) begin
                if (capture) begin
                    type_q  <= instr_type_in;
                    waddr_q <= rf_waddr_id_i;
                    wdata_q <= rf_wdata_id_i;
                    we_q    <= rf_we_id_i;
                end
            end
        end
    end else begin : g_pass
        // Pass-through mode keeps no entry; ties make every held-state term inert.
        assign valid_q = 1'b0;
        assign type_q  = WB_INSTR_OTHER;
        assign waddr_q = 5'd0;
        assign wdata_q = 32'd0;
        assign we_q    = 1'b0;
    end

    // Sticky flag for an LSU response that had no load/store to match.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            unexp_q <= 1'b0;
        end else begin
            unexp_q <= unexp_d;
        end
    end

    assign resp_unexpected_o = unexp_q;

    // Output decode: held entry in registered mode, qualified inputs in pass-through mode.
    always_comb begin
        ready_wb_o            = 1'b1;
        rf_waddr_wb_o         = 5'd0;
        rf_wdata_wb_o         = 32'd0;
        rf_we_wb_o            = 1'b0;
        outstanding_load_wb_o = 1'b0;
        instr_done_wb_o       = 1'b0;
        if (WritebackStage) begin
            ready_wb_o            = ~valid_q | completing;
            outstanding_load_wb_o = valid_q & (type_q == WB_INSTR_LOAD) & ~lsu_resp_valid_i;
            instr_done_wb_o       = completing;
            rf_we_wb_o            = completing & we_q &
                                    ((type_q == WB_INSTR_REG) |
                                     ((type_q == WB_INSTR_LOAD) & ~lsu_resp_err_i));
            if (valid_q) begin
                rf_waddr_wb_o = waddr_q;
                // Load data bypasses the register so the write lands in the response cycle.
                rf_wdata_wb_o = ((type_q == WB_INSTR_LOAD) && lsu_resp_valid_i) ? lsu_rdata_i
                                                                                 : wdata_q;
            end
        end else if (en_wb_i) begin
            rf_waddr_wb_o   = rf_waddr_id_i;
            rf_wdata_wb_o   = rf_wdata_id_i;
            rf_we_wb_o      = rf_we_id_i & (instr_type_in == WB_INSTR_REG);
            instr_done_wb_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_ibex_wb_pipe.sv
// Scoreboard bench for ibex_wb_pipe: stimulus pushes expected retirements,
// a negedge monitor pops and compares whenever instr_done_wb_o is seen.
module tb_ibex_wb_pipe;

    logic        clk;
    logic        rst_n;
    logic        en_wb;
    logic [1:0]  instr_type;
    logic [4:0]  waddr_id;
    logic [31:0] wdata_id;
    logic        we_id;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] rdata;
    logic        ready_wb;
    logic [4:0]  waddr_wb;
    logic [31:0] wdata_wb;
    logic        we_wb;
    logic        outstanding;
    logic        done;
    logic        unexp;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cycle;
    } exp_t;

    exp_t sb[$];

    ibex_wb_pipe #(.WritebackStage(1'b1), .ResetAll(1'b0)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .en_wb_i               (en_wb),
        .instr_type_wb_i       (instr_type),
        .rf_waddr_id_i         (waddr_id),
        .rf_wdata_id_i         (wdata_id),
        .rf_we_id_i            (we_id),
        .lsu_resp_valid_i      (resp_valid),
        .lsu_resp_err_i        (resp_err),
        .lsu_rdata_i           (rdata),
        .ready_wb_o            (ready_wb),
        .rf_waddr_wb_o         (waddr_wb),
        .rf_wdata_wb_o         (wdata_wb),
        .rf_we_wb_o            (we_wb),
        .outstanding_load_wb_o (outstanding),
        .instr_done_wb_o       (done),
        .resp_unexpected_o     (unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] t, input logic [4:0] a,
                         input logic [31:0] d, input logic we);
        en_wb      = en;
        instr_type = t;
        waddr_id   = a;
        wdata_id   = d;
        we_id      = we;
    endtask

    task automatic resp(input logic v, input logic err, input logic [31:0] d);
        resp_valid = v;
        resp_err   = err;
        rdata      = d;
    endtask

    task automatic push(input logic we, input logic [4:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.we    = we;
        e.addr  = a;
        e.data  = d;
        e.cycle = c;
        sb.push_back(e);
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every retirement must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ret_we", 32'(we_wb), 32'(e.we));
                chk("ret_addr", 32'(waddr_wb), 32'(e.addr));
                chk("ret_data", wdata_wb, e.data);
                chk("ret_cycle", 32'(cyc), 32'(e.cycle));
            end
        end
        if (rst_n && we_wb && !done) begin
            chk("we_without_done", 32'(we_wb), 32'd0);
        end
    end

    initial begin
        int l;
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 5'd0, 32'd0, 1'b0);
        resp(1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);

        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(ready_wb), 32'd1);
        chk("rst_we", 32'(we_wb), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_unexp", 32'(unexp), 32'd0);
        chk("rst_waddr", 32'(waddr_wb), 32'd0);
        chk("rst_wdata", wdata_wb, 32'd0);
        rst_n = 1'b1;
        step();

        // Single ALU write, done for exactly one cycle
        drive(1'b1, 2'd0, 5'd5, 32'hDEADBEEF, 1'b1);
        push(1'b1, 5'd5, 32'hDEADBEEF, cyc + 1);
        step();
        drive(1'b0, 2'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("alu_we", 32'(we_wb), 32'd1);
        step();
        @(negedge clk);
        chk("alu_done_pulse", 32'(done), 32'd0);
        step();

        // Back-to-back ALU writes x1 then x2
        drive(1'b1, 2'd0, 5'd1, 32'h00000011, 1'b1);
        push(1'b1, 5'd1, 32'h00000011, cyc + 1);
        @(negedge clk);
        chk("b2b_ready0", 32'(ready_wb), 32'd1);
        step();
        drive(1'b1, 2'd0, 5'd2, 32'h00000022, 1'b1);
        push(1'b1, 5'd2, 32'h00000022, cyc + 1);
        @(negedge clk);
        chk("b2b_ready1", 32'(ready_wb), 32'd1);
        step();
        drive(1'b0, 2'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("b2b_ready2", 32'(ready_wb), 32'd1);
        step();

        // Load to x7, response three cycles after issue, ALU captured in response cycle
        l = cyc;
        drive(1'b1, 2'd1, 5'd7, 32'h0000AAAA, 1'b1);
        push(1'b1, 5'd7, 32'h12345678, l + 3);
        step();
        drive(1'b0, 2'd0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("ld_ready_stall", 32'(ready_wb), 32'd0);
            chk("ld_outstanding", 32'(outstanding), 32'd1);
            step();
        end
        resp(1'b1, 1'b0, 32'h12345678);
        drive(1'b1, 2'd0, 5'd3, 32'h00000055, 1'b1);
        push(1'b1, 5'd3, 32'h00000055, l + 4);
        @(negedge clk);
        chk("ld_resp_ready", 32'(ready_wb), 32'd1);
        chk("ld_resp_outstanding", 32'(outstanding), 32'd0);
        step();
        resp(1'b0, 1'b0, 32'd0);
        drive(1'b0, 2'd0, 5'd0, 32'd0, 1'b0);
        step();

        // Load error: retires without a write
        drive(1'b1, 2'd1, 5'd9, 32'h0, 1'b1);
        push(1'b0, 5'd9, 32'hCAFEF00D, cyc + 1);
        step();
        drive(1'b0, 2'd0, 5'd0, 32'd0, 1'b0);
        resp(1'b1, 1'b1, 32'hCAFEF00D);
        step();
        resp(1'b0, 1'b0, 32'd0);

        // Store: no write even with we set, held data presented
        drive(1'b1, 2'd2, 5'd4, 32'h00001111, 1'b1);
        push(1'b0, 5'd4, 32'h00001111, cyc + 2);
        step();
        drive(1'b0, 2'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("st_wait_ready", 32'(ready_wb), 32'd0);
        chk("st_outstanding", 32'(outstanding), 32'd0);
        step();
        resp(1'b1, 1'b0, 32'hFFFFFFFF);
        step();
        resp(1'b0, 1'b0, 32'd0);

        // Type 3 retires next cycle with no write
        drive(1'b1, 2'd3, 5'd6, 32'h00000066, 1'b1);
        push(1'b0, 5'd6, 32'h00000066, cyc + 1);
        step();
        drive(1'b0, 2'd0, 5'd0, 32'd0, 1'b0);
        step();
        @(negedge clk);
        chk("pre_unexp", 32'(unexp), 32'd0);

        // Unexpected response in EMPTY: sticky flag, no retirement
        step();
        resp(1'b1, 1'b0, 32'h0BADF00D);
        step();
        resp(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        chk("unexp_set", 32'(unexp), 32'd1);
        chk("unexp_no_done", 32'(done), 32'd0);
        repeat (3) step();
        @(negedge clk);
        chk("unexp_sticky", 32'(unexp), 32'd1);

        // Reset while a load is held, then a late response
        step();
        drive(1'b1, 2'd1, 5'd10, 32'h0, 1'b1);
        step();
        drive(1'b0, 2'd0, 5'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("rml_outstanding", 32'(outstanding), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rml_rst_outstanding", 32'(outstanding), 32'd0);
        chk("rml_rst_ready", 32'(ready_wb), 32'd1);
        chk("rml_rst_unexp", 32'(unexp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        resp(1'b1, 1'b0, 32'h77777777);
        @(negedge clk);
        chk("rml_resp_done", 32'(done), 32'd0);
        chk("rml_resp_we", 32'(we_wb), 32'd0);
        step();
        resp(1'b0, 1'b0, 32'd0);
        @(negedge clk);
        chk("rml_unexp", 32'(unexp), 32'd1);
        chk("rml_ready", 32'(ready_wb), 32'd1);
        step();

        // Every expected retirement must have been observed
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
